watch_set_controller: RTL
=========================

# watch_set_controller

Mode/set controller for the min:sec watch datapath. Consumes the 1 s tick pulse from the clock divider chain plus three pre-debounced, single-cycle button pulses. Sequences a run/set state machine and owns the BCD minute and second registers. Outputs feed the FND digit mux directly.

## Interface

Parameters:
- none; all field moduli fixed at 60.

Ports:
- clk  in  1  system clock (100 MHz board clock).
- reset_p  in  1  reset, asynchronous, active-high.
- tick_sec  in  1  one-cycle pulse, once per second, from the divider chain.
- btn_mode  in  1  one-cycle pulse; enter/leave set mode.
- btn_sel  in  1  one-cycle pulse; toggle the field being edited.
- btn_inc  in  1  one-cycle pulse; increment the edited field.
- sec1, sec10  out  4 each  BCD seconds, ones/tens; sec10 range 0-5.
- min1, min10  out  4 each  BCD minutes, ones/tens; min10 range 0-5.
- set_mode  out  1  high in SET_MIN/SET_SEC.
- field_sel  out  1  0 = minutes edited, 1 = seconds edited; 0 in RUN.
- blink  out  1  display-blank strobe for the edited field.
- min_wrap  out  1  one-cycle pulse on 59:59 -> 00:00 rollover in RUN.

## Operation

- States (2-bit): RUN, SET_MIN, SET_SEC. Reset state is RUN.
- RUN:
  - tick_sec increments seconds.
  - 59 -> 00 on seconds increments minutes in the same cycle.
  - 59 -> 00 on minutes asserts min_wrap.
  - btn_sel and btn_inc are ignored.
- RUN + btn_mode -> SET_MIN.
- SET_MIN / SET_SEC:
  - tick_sec never changes time.
  - btn_sel toggles SET_MIN <-> SET_SEC.
  - btn_inc increments the selected field mod 60 with no carry into minutes (seconds 59 -> 00 leaves minutes unchanged).
  - btn_mode -> RUN.
  - Seconds keep their value on exit; no clearing.
- BCD increment rule:
  - ones 9 -> 0 with tens+1.
  - tens 5 with ones 9 -> 00.
  - Values never leave 00-59.
- Priority within one cycle: btn_mode > btn_sel > btn_inc > tick_sec.
  - A lower-priority event in the same cycle is dropped, not queued.
  - Exception: in RUN, tick_sec is still applied when btn_mode arrives in the same cycle (time advance happens before freeze).
- blink:
  - Toggles on every tick_sec while in SET states.
  - Forced 0 in RUN.
  - Cleared to 0 on every state transition.

## Timing

- All outputs are registered. Response to any input pulse is visible on the first clk edge after the pulse cycle (latency 1).
- Reset values: all BCD digits 0, set_mode 0, field_sel 0, blink 0, min_wrap 0, state RUN.
- min_wrap is high for exactly one cycle, coincident with digits reading 00:00.
- Back-to-back pulses on consecutive cycles are each honoured (no lockout).
- reset_p asserted mid-edit returns to RUN with 00:00 immediately (asynchronous). The first tick after release counts.
- Inputs are assumed synchronous single-cycle pulses. Held-high inputs count once per cycle; the upstream edge detector is responsible for pulse shaping.

## Structure

- Shared package `clock_pkg`:
  - state enum (RUN=0, SET_MIN=1, SET_SEC=2).
  - BCD_MAX_ONES=9, BCD_MAX_TENS=5.
- Sub-module `bcd_mod60_counter`: one each for seconds and minutes.
  - Inputs: inc, clk, reset_p.
  - Outputs: ones, tens, wrap (combinational; high when inc at 59).
- The top level holds the FSM, priority logic, carry gating (minutes inc = RUN and sec wrap, or SET_MIN and btn_inc), blink and min_wrap registers.

## Test plan

- Reset, then 61 tick_sec pulses in RUN -> 01:01. set_mode=0, min_wrap never high.
- Preload 59:58 via set mode, return to RUN, 2 ticks -> 00:00 with min_wrap high exactly one cycle on the second.
- btn_mode, 3x btn_inc -> minutes +3. btn_sel, 61x btn_inc -> seconds +1 mod 60, minutes unchanged. Ticks meanwhile change nothing.
- Same-cycle btn_mode+btn_inc in RUN -> SET_MIN, no increment. Same-cycle btn_inc+tick_sec in SET_SEC -> seconds +1 only.
- blink toggles per tick in SET states, 0 after btn_mode back to RUN. field_sel tracks btn_sel.
- reset_p pulsed in SET_SEC at 12:34 -> next edge RUN, 00:00, all flags 0.

Source files
------------

// File: rtl/clock_pkg.sv
// Shared types and constants for the min:sec watch datapath.
package clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_MIN = 2'd1,
        SET_SEC = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX_ONES = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS = 4'd5;

endpackage

// File: rtl/bcd_mod60_counter.sv
// Two-digit BCD counter, 00..59, advancing by one on each inc cycle.
module bcd_mod60_counter
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       inc,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       wrap
);

    // Wrap is combinational so the caller can carry in the same cycle.
    assign wrap = inc && (ones == BCD_MAX_ONES) && (tens == BCD_MAX_TENS);

    // BCD increment: ones 9 -> 0 carries into tens; 59 -> 00.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            ones <= 4'd0;
            tens <= 4'd0;
        end else if (inc) begin
            if (ones == BCD_MAX_ONES) begin
                ones <= 4'd0;
                tens <= (tens == BCD_MAX_TENS) ? 4'd0 : tens + 4'd1;
            end else begin
                ones <= ones + 4'd1;
            end
        end
    end

endmodule

// File: rtl/watch_set_controller.sv
// Run/set mode controller owning the BCD minute and second registers.
module watch_set_controller
    import clock_pkg::*;
(
    input  logic       clk,
    input  logic       reset_p,
    input  logic       tick_sec,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic       set_mode,
    output logic       field_sel,
    output logic       blink,
    output logic       min_wrap
);

    state_t state;
    logic   set_inc;
    logic   set_tick;
    logic   sec_inc;
    logic   min_inc;
    logic   sec_wrap;
    logic   min_wrap_c;

    // Priority chain for set mode: mode > sel > inc > tick; losers are dropped.
    assign set_inc  = !btn_mode && !btn_sel && btn_inc;
    assign set_tick = !btn_mode && !btn_sel && !btn_inc && tick_sec;

    // In RUN the tick applies even alongside btn_mode (advance before freeze).
    assign sec_inc = ((state == RUN) && tick_sec) || ((state == SET_SEC) && set_inc);
    // Carry into minutes only while running; set-mode seconds wrap silently.
    assign min_inc = ((state == RUN) && sec_wrap) || ((state == SET_MIN) && set_inc);

    bcd_mod60_counter u_sec (
        .clk     (clk),
        .reset_p (reset_p),
        .inc     (sec_inc),
        .ones    (sec1),
        .tens    (sec10),
        .wrap    (sec_wrap)
    );

    bcd_mod60_counter u_min (
        .clk     (clk),
        .reset_p (reset_p),
        .inc     (min_inc),
        .ones    (min1),
        .tens    (min10),
        .wrap    (min_wrap_c)
    );

    // Mode FSM with registered flags; blink clears on every transition.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state     <= RUN;
            set_mode  <= 1'b0;
            field_sel <= 1'b0;
            blink     <= 1'b0;
            min_wrap  <= 1'b0;
        end else begin
            min_wrap <= (state == RUN) && min_wrap_c;
            case (state)
                RUN: begin
                    blink <= 1'b0;
                    if (btn_mode) begin
                        state     <= SET_MIN;
                        set_mode  <= 1'b1;
                        field_sel <= 1'b0;
                    end
                end
                SET_MIN, SET_SEC: begin
                    if (btn_mode) begin
                        state     <= RUN;
                        set_mode  <= 1'b0;
                        field_sel <= 1'b0;
                        blink     <= 1'b0;
                    end else if (btn_sel) begin
                        state     <= (state == SET_MIN) ? SET_SEC : SET_MIN;
                        field_sel <= (state == SET_MIN);
                        blink     <= 1'b0;
                    end else if (set_tick) begin
                        blink <= ~blink;
                    end
                end
                default: begin
                    state     <= RUN;
                    set_mode  <= 1'b0;
                    field_sel <= 1'b0;
                    blink     <= 1'b0;
                end
            endcase
        end
    end

endmodule
